// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forward-select codes, memory-wait FSM encoding, default widths.
package hazard_ctrl_unit_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: EX forwarding, load-use/RAW stall, branch flush,
// data-memory wait FSM with timeout, and saturating perf counters.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic              RegWriteE,
  input  logic              ResultSrcE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemReqM,
  input  logic              MemAckM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              BubbleW,
  output logic              mem_timeout_err,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events,
  output logic [CNT_W-1:0]  load_use_events
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  mem_state_e       state, state_n;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;

  logic m_valid, w_valid, e_valid;
  logic luse, raw, dstall, mstall;
  logic stall_fd;

  assign m_valid = RegWriteM && (RD_M != '0);
  assign w_valid = RegWriteW && (RD_W != '0);
  assign e_valid = RD_E != '0;

  always_comb begin
    ForwardAE = FWD_NONE;
    ForwardBE = FWD_NONE;
    if (FWD_EN != 0) begin
      if (m_valid && (RD_M == Rs1_E))
        ForwardAE = FWD_M;
      else if (w_valid && (RD_W == Rs1_E))
        ForwardAE = FWD_W;
      if (m_valid && (RD_M == Rs2_E))
        ForwardBE = FWD_M;
      else if (w_valid && (RD_W == Rs2_E))
        ForwardBE = FWD_W;
    end
  end

  assign luse = ResultSrcE && e_valid &&
                ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  // W writes the register file before D reads it, so only E and M matter.
  assign raw = (FWD_EN == 0) && (
      (RegWriteE && e_valid &&
       ((RD_E == Rs1_D) || (RD_E == Rs2_D))) ||
      (m_valid && ((RD_M == Rs1_D) || (RD_M == Rs2_D))));

  assign dstall = luse || raw;
  assign mstall = (MemReqM && !MemAckM) || (state == ERR);

  // A taken branch squashes decode, so it cancels the decode stall.
  assign stall_fd = mstall || (dstall && !PCSrcE);

  assign StallF  = stall_fd;
  assign StallD  = stall_fd;
  assign StallE  = mstall;
  assign StallM  = mstall;
  assign BubbleW = mstall;
  assign FlushD  = !mstall && PCSrcE;
  assign FlushE  = !mstall && (PCSrcE || dstall);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    unique case (state)
      IDLE: begin
        if (MemReqM && !MemAckM) begin
          state_n    = WAIT;
          wait_cnt_n = CNT_W'(1);
        end
      end
      WAIT: begin
        if (MemReqM && MemAckM)
          state_n = IDLE;
        else if (wait_cnt == TO_LAST)
          state_n = ERR;
        else
          wait_cnt_n = wait_cnt + CNT_W'(1);
      end
      ERR:     state_n = ERR;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    mem_timeout_err = (state == ERR);
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (StallF),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (PCSrcE && !mstall),
    .count (flush_events)
  );

  sat_counter #(.CNT_W(CNT_W)) u_luse_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (luse && !mstall && !PCSrcE),
    .count (load_use_events)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with an expected-value queue.
// Two instances: forwarding with 32-bit counters, and no-forwarding with 4-bit.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic       RegWriteE, ResultSrcE, PCSrcE;
  logic       RegWriteM, RegWriteW, MemReqM, MemAckM;

  logic [1:0]  fa, fb;
  logic        stf, std, ste, stm, fld, fle, bw, err;
  logic [31:0] c_stall, c_flush, c_luse;

  logic [1:0] n_fa, n_fb;
  logic       n_stf, n_std, n_ste, n_stm, n_fld, n_fle, n_bw, n_err;
  logic [3:0] n_stall, n_flush, n_luse;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_ctrl_unit #(
    .REG_AW(5), .FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .RD_M(RD_M), .RD_W(RD_W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemAckM(MemAckM),
    .ForwardAE(fa), .ForwardBE(fb),
    .StallF(stf), .StallD(std), .StallE(ste), .StallM(stm),
    .FlushD(fld), .FlushE(fle), .BubbleW(bw),
    .mem_timeout_err(err),
    .stall_cycles(c_stall), .flush_events(c_flush),
    .load_use_events(c_luse)
  );

  hazard_ctrl_unit #(
    .REG_AW(5), .FWD_EN(0), .MEM_TIMEOUT(4), .CNT_W(4)
  ) dut_nf (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .RD_M(RD_M), .RD_W(RD_W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemAckM(MemAckM),
    .ForwardAE(n_fa), .ForwardBE(n_fb),
    .StallF(n_stf), .StallD(n_std), .StallE(n_ste), .StallM(n_stm),
    .FlushD(n_fld), .FlushE(n_fle), .BubbleW(n_bw),
    .mem_timeout_err(n_err),
    .stall_cycles(n_stall), .flush_events(n_flush),
    .load_use_events(n_luse)
  );

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL sb_empty observed=%0h expected=none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic clr();
    Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0;
    RD_E = '0; RD_M = '0; RD_W = '0;
    RegWriteE = 0; ResultSrcE = 0; PCSrcE = 0;
    RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemAckM = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    push("rst_err", 0);   push("rst_stall", 0);
    push("rst_flush", 0); push("rst_luse", 0);
    push("rst_stallf", 0); push("rst_fa", 0);
    chk(32'(err)); chk(c_stall); chk(c_flush); chk(c_luse);
    chk(32'(stf)); chk(32'(fa));
    rst = 1'b0;

    // forwarding priority M over W
    RD_M = 5; RegWriteM = 1; RD_W = 5; RegWriteW = 1;
    Rs1_E = 5; Rs2_E = 5;
    push("fwd_m_a", 2); push("fwd_m_b", 2);
    #1; chk(32'(fa)); chk(32'(fb));
    RegWriteM = 0;
    push("fwd_w_a", 1); push("fwd_w_b", 1);
    #1; chk(32'(fa)); chk(32'(fb));
    RegWriteM = 1; RD_M = 0;
    push("fwd_x0_a", 1); push("fwd_x0_b", 1);
    #1; chk(32'(fa)); chk(32'(fb));
    RD_W = 0;
    push("fwd_none_a", 0);
    #1; chk(32'(fa));
    @(negedge clk);

    // load-use
    clr();
    ResultSrcE = 1; RegWriteE = 1; RD_E = 7; Rs1_D = 1; Rs2_D = 7;
    push("lu_stallf", 1); push("lu_stalld", 1); push("lu_flushe", 1);
    push("lu_flushd", 0); push("lu_stalle", 0);
    #1; chk(32'(stf)); chk(32'(std)); chk(32'(fle));
    chk(32'(fld)); chk(32'(ste));
    @(negedge clk);
    push("lu_cnt_luse", 1); push("lu_cnt_stall", 1);
    chk(c_luse); chk(c_stall);
    RD_E = 0;
    push("lu_x0_stallf", 0); push("lu_x0_flushe", 0);
    #1; chk(32'(stf)); chk(32'(fle));
    @(negedge clk);
    push("lu_x0_luse", 1); push("lu_x0_stall", 1);
    chk(c_luse); chk(c_stall);

    // branch beats load-use
    RD_E = 7; PCSrcE = 1;
    push("br_flushd", 1); push("br_flushe", 1);
    push("br_stallf", 0); push("br_stalld", 0);
    #1; chk(32'(fld)); chk(32'(fle)); chk(32'(stf)); chk(32'(std));
    @(negedge clk);
    push("br_flush_cnt", 1); push("br_luse_cnt", 1);
    push("br_stall_cnt", 1);
    chk(c_flush); chk(c_luse); chk(c_stall);

    // memory wait of 3 cycles with pending branch
    clr();
    MemReqM = 1; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      push("mw_stallf", 1); push("mw_stalle", 1);
      push("mw_stallm", 1); push("mw_bubble", 1); push("mw_flushd", 0);
      #1; chk(32'(stf)); chk(32'(ste)); chk(32'(stm));
      chk(32'(bw)); chk(32'(fld));
      @(negedge clk);
    end
    push("mw_stall_cnt", 4); push("mw_flush_held", 1);
    chk(c_stall); chk(c_flush);
    MemAckM = 1;
    push("ack_stallf", 0); push("ack_stallm", 0);
    push("ack_bubble", 0); push("ack_flushd", 1);
    #1; chk(32'(stf)); chk(32'(stm)); chk(32'(bw)); chk(32'(fld));
    @(negedge clk);
    push("ack_flush_cnt", 2); push("ack_err", 0); push("ack_stall_cnt", 4);
    chk(c_flush); chk(32'(err)); chk(c_stall);

    // timeout into ERR on the 4th edge
    clr();
    MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push("to_pre_err", 0);
      chk(32'(err));
    end
    @(negedge clk);
    push("to_err", 1);
    chk(32'(err));
    MemAckM = 1;
    push("to_late_stallf", 1); push("to_late_stallm", 1);
    #1; chk(32'(stf)); chk(32'(stm));
    @(negedge clk);
    push("to_err_sticky", 1); push("to_stall_sticky", 1);
    chk(32'(err)); chk(32'(stf));
    rst = 1'b1;
    @(negedge clk);
    push("to_rst_err", 0); push("to_rst_stallf", 0);
    push("to_rst_stall", 0); push("to_rst_flush", 0);
    push("to_rst_luse", 0); push("to_rst_n_stall", 0);
    chk(32'(err)); chk(32'(stf)); chk(c_stall); chk(c_flush);
    chk(c_luse); chk(32'(n_stall));
    rst = 1'b0;

    // no-forwarding instance: RAW stall from M
    clr();
    RegWriteM = 1; RD_M = 3; Rs1_D = 3; Rs1_E = 3;
    push("nf_m_stallf", 1); push("nf_m_stalld", 1);
    push("nf_m_flushe", 1); push("nf_m_fa", 0);
    push("fw_m_fa", 2); push("fw_m_stallf", 0);
    #1; chk(32'(n_stf)); chk(32'(n_std)); chk(32'(n_fle));
    chk(32'(n_fa)); chk(32'(fa)); chk(32'(stf));
    @(negedge clk);
    push("nf_m_cnt", 1);
    chk(32'(n_stall));
    RegWriteM = 0; RegWriteW = 1; RD_W = 3;
    push("nf_w_stallf", 0); push("fw_w_fa", 1);
    #1; chk(32'(n_stf)); chk(32'(fa));
    @(negedge clk);

    // RAW from a non-load in E, then counter saturation
    clr();
    RegWriteE = 1; RD_E = 3; Rs2_D = 3;
    push("nf_e_stallf", 1); push("fw_e_stallf", 0);
    #1; chk(32'(n_stf)); chk(32'(stf));
    repeat (20) @(negedge clk);
    push("nf_sat", 15); push("fw_stall_cnt", 0);
    chk(32'(n_stall)); chk(c_stall);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the forwarding-only hazard block of the 5-stage RV32 pipeline.
- Adds three things on top of EX-stage forwarding:
  - load-use stall and branch flush generation;
  - a multi-cycle data-memory wait FSM with timeout;
  - saturating performance counters.
- Sits beside the stage modules in the pipeline top and drives the stall/flush controls of every pipeline register.

Parameters:
- REG_AW, 5, register index width.
- FWD_EN, 1, 1 = forward from M/W; 0 = no forwarding, RAW hazards resolved by D-stage stall.
- MEM_TIMEOUT, 16, max wait cycles for MemAckM before error; legal range 2..2^CNT_W-1.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- Rs1_D, Rs2_D  in  REG_AW  source registers of the instruction in decode
- Rs1_E, Rs2_E  in  REG_AW  source registers of the instruction in execute
- RD_E  in  REG_AW  destination register in execute
- RegWriteE  in  1  execute-stage instruction writes a register
- ResultSrcE  in  1  execute-stage instruction is a load
- PCSrcE  in  1  branch/jump taken in execute
- RD_M, RD_W  in  REG_AW  destination registers in memory / writeback
- RegWriteM, RegWriteW  in  1  register-write enables in memory / writeback
- MemReqM  in  1  load/store access active in memory stage
- MemAckM  in  1  data memory completes the access this cycle
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 10 ALU_ResultM, 01 ResultW
- StallF, StallD, StallE, StallM  out  1  hold PC / pipeline register
- FlushD, FlushE  out  1  clear D / E pipeline register to a bubble
- BubbleW  out  1  load a bubble into the M->W register
- mem_timeout_err  out  1  sticky timeout flag
- stall_cycles, flush_events, load_use_events  out  CNT_W  performance counters

Behaviour:
- Hazard outputs are combinational from inputs and the FSM state. Counters and FSM are registered. No other latency.
- Forwarding (FWD_EN=1):
  - ForwardAE = 10 if RegWriteM & RD_M!=0 & RD_M==Rs1_E.
  - Else ForwardAE = 01 if RegWriteW & RD_W!=0 & RD_W==Rs1_E.
  - Else ForwardAE = 00.
  - ForwardBE is the same using Rs2_E. M has priority over W.
- Forwarding (FWD_EN=0): ForwardAE = ForwardBE = 00.
- Load-use:
  - luse = ResultSrcE & RD_E!=0 & (RD_E==Rs1_D | RD_E==Rs2_D).
  - Both sources are always compared (conservative).
- FWD_EN=0 RAW stall:
  - raw = (RegWriteE & RD_E!=0 & RD_E matches Rs1_D/Rs2_D) | (RegWriteM & RD_M!=0 & RD_M matches Rs1_D/Rs2_D).
  - The writeback stage writes the register file before decode reads it, so W never needs a stall.
- dstall = luse | raw. On dstall: StallF=StallD=1 and FlushE=1.
- Branch: PCSrcE gives FlushD=FlushE=1. If PCSrcE and dstall occur together, the branch wins: StallF=StallD=0, because the decode instruction is squashed.
- Memory wait:
  - mstall = (MemReqM & ~MemAckM) | (state==ERR).
  - On mstall: StallF=StallD=StallE=StallM=1, BubbleW=1, FlushD=FlushE=0.
  - mstall overrides dstall and branch handling. Those are re-evaluated once the stall releases, because E is held so PCSrcE stays stable.
- FSM states: IDLE, WAIT, ERR.
  - IDLE -> WAIT when MemReqM & ~MemAckM; wait_cnt <= 1.
  - WAIT: if MemAckM -> IDLE; the stall releases in that same cycle (combinational).
  - WAIT: else if wait_cnt == MEM_TIMEOUT-1 -> ERR.
  - WAIT: else wait_cnt increments.
  - ERR is absorbing until rst. mem_timeout_err=1 while in ERR and all stalls are held.
  - MemAckM without MemReqM is ignored.
- Counters, each saturating at 2^CNT_W-1:
  - stall_cycles increments on any cycle with StallF=1.
  - flush_events increments on each cycle PCSrcE is applied (i.e. not masked by mstall).
  - load_use_events increments on each cycle luse causes a stall.
- Reset (synchronous):
  - state=IDLE, wait_cnt=0, mem_timeout_err=0, all counters=0.
  - rst during WAIT or ERR returns to IDLE next edge.
  - Combinational outputs follow inputs even during rst, except mstall from ERR, which clears at reset.

Decomposition:
- Shared package holds:
  - forward-select constants FWD_NONE=00, FWD_W=01, FWD_M=10;
  - FSM state encoding IDLE/WAIT/ERR;
  - REG_AW default.
- One natural sub-module: sat_counter (parameter CNT_W; inputs clk, rst, inc; output count), instantiated three times.
- FSM and hazard logic stay in the top.

Test Plan:
- Forwarding, FWD_EN=1: RD_M=5/RegWriteM=1 and RD_W=5/RegWriteW=1 with Rs1_E=5, Rs2_E=5 -> ForwardAE=ForwardBE=10. Then drop RegWriteM -> both 01. With RD_M=0 -> never 10.
- Load-use: ResultSrcE=1, RD_E=7, Rs2_D=7 -> StallF=StallD=FlushE=1 for one cycle; load_use_events 0->1, stall_cycles 0->1. Repeat with RD_E=0 -> no stall.
- Branch with simultaneous load-use: PCSrcE=1 with the load-use condition -> FlushD=FlushE=1, StallF=StallD=0, flush_events=1, load_use_events unchanged.
- Memory wait: MemReqM=1 with MemAckM low for 3 cycles, then high -> all four stalls and BubbleW high for exactly 3 cycles and low in the ack cycle, FSM back in IDLE, stall_cycles=3. A concurrent PCSrcE produces no flush until the ack cycle.
- Timeout: MEM_TIMEOUT=4, MemReqM=1, no ack -> ERR entered on the 4th edge, mem_timeout_err=1 and stalls stay high despite a late MemAckM. rst=1 for one edge -> IDLE, flag=0, counters=0.
- FWD_EN=0: RegWriteM=1, RD_M=3, Rs1_D=3 -> StallF=StallD=FlushE=1 and ForwardAE=00. Same with RD_W=3 only -> no stall.
